// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_arb_pkg
//  Description : Shared constants, state encoding and helpers for the
//                register-file write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int NREQ    = 4;
    localparam int NREG    = 16;
    localparam int DW      = 32;
    localparam int RIDX_W  = 4;
    localparam int MAXLOCK = 8;
    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W   = $clog2(MAXLOCK + 1);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef logic [RIDX_W-1:0] reg_idx_t;
    typedef logic [DW-1:0]     word_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    // Requester index after p, wrapping at NREQ.
    function automatic ptr_t next_ptr(input ptr_t p);
        return (int'(p) == NREQ - 1) ? '0 : ptr_t'(p + 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_if
//  Description : Requester handshake and register-file write bus.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_write_arbiter_if
    import regfile_arb_pkg::*;
;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ*RIDX_W-1:0] widx;
    logic [NREQ*DW-1:0]     wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREG-1:0]        reg_in;
    word_t                  BusMuxOut;
    reg_idx_t               grant_id;
    logic                   locked;

    modport master (
        output req, lock, widx, wdata,
        input  gnt, reg_in, BusMuxOut, grant_id, locked
    );

    modport slave (
        input  req, lock, widx, wdata,
        output gnt, reg_in, BusMuxOut, grant_id, locked
    );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational rotate-priority pick; highest priority at i_ptr.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    int w_idx;

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        o_gnt = '0;
        w_idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_req[w_idx[PW-1:0]]) begin
                o_gnt = '0;
                o_gnt[w_idx[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Round-robin/locking arbiter for the register-file write port
//                with a one-cycle registered write stage.
//                Optional: REG0_READONLY_EN suppresses all writes to r0.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_arb_pkg::*;
(
    input logic                    clk,
    input logic                    clr,
    regfile_write_arbiter_if.slave bus
);

    arb_state_t       r_state, w_state_nxt;
    ptr_t             r_rr_ptr, w_rr_ptr_nxt;
    ptr_t             r_owner, w_owner_nxt;
    ptr_t             w_gidx;
    logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic [NREQ-1:0]  w_rr_gnt, w_gnt;
    logic             w_xfer;
    reg_idx_t         w_widx;
    word_t            w_wdata;
    logic [NREG-1:0]  w_wen;
    logic [NREG-1:0]  r_reg_in;
    word_t            r_bus_out;
    reg_idx_t         r_grant_id;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PTR_W)
    ) u_rr_arbiter (
        .i_req (bus.req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt)
    );

    // Nothing is offered while clr is low, so no transfer can race the reset.
    always_comb begin
        w_gnt = '0;
        if (clr) begin
            if (r_state == ARB) begin
                w_gnt = w_rr_gnt;
            end else if (bus.req[r_owner]) begin
                w_gnt[r_owner] = 1'b1;
            end
        end
    end

    assign w_xfer = |(bus.req & w_gnt);

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_gidx = ptr_t'(i);
        end
    end

    assign w_widx  = bus.widx[int'(w_gidx)*RIDX_W +: RIDX_W];
    assign w_wdata = bus.wdata[int'(w_gidx)*DW +: DW];

    // Out-of-range indices are accepted but produce no enable.
    always_comb begin
        w_wen = '0;
        if (int'(w_widx) < NREG) w_wen[w_widx] = 1'b1;
`ifdef REG0_READONLY_EN
        if (w_widx == '0) w_wen = '0;
`endif
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        if (w_xfer) begin
            w_rr_ptr_nxt = next_ptr(w_gidx);
            case (r_state)
                ARB: begin
                    if (bus.lock[w_gidx] && (MAXLOCK > 1)) begin
                        w_state_nxt    = LOCKED;
                        w_owner_nxt    = w_gidx;
                        w_lock_cnt_nxt = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    // The transfer that reaches MAXLOCK completes, then the lock is released.
                    if (!bus.lock[w_gidx] || (int'(r_lock_cnt) + 1 >= MAXLOCK)) begin
                        w_state_nxt    = ARB;
                        w_lock_cnt_nxt = '0;
                    end else begin
                        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt    = ARB;
                    w_lock_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= ARB;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_reg_in   <= '0;
            r_bus_out  <= '0;
            r_grant_id <= '0;
        end else if (w_xfer) begin
            r_reg_in   <= w_wen;
            r_bus_out  <= w_wdata;
            r_grant_id <= reg_idx_t'(w_gidx);
        end else begin
            r_reg_in   <= '0;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.reg_in    = r_reg_in;
    assign bus.BusMuxOut = r_bus_out;
    assign bus.grant_id  = r_grant_id;
    assign bus.locked    = (r_state == LOCKED);

endmodule
`default_nettype wire
